dma_mem_ctrl: RTL and testbench

//   Timed main-memory controller sitting directly downstream of the bus

---
 rtl/dma_mem_ctrl.sv | 126 ++++++++++++
 tb/tb_dma_mem_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_mem_ctrl.sv
// Timed block memory controller: accepts one block request at a time, waits a
// fixed access latency, then moves one 32-bit word per cycle between the
// request and an internal word array, finishing with a one-cycle valid pulse.
module dma_mem_ctrl #(
    parameter int unsigned els_p            = 2048,
    parameter int unsigned dma_data_width_p = 8,
    parameter int unsigned latency_p        = 4
) (
    input  logic                              clk_i,
    input  logic                              nreset_i,
    input  logic                              mem_valid_i,
    output logic                              mem_ready_o,
    input  logic                              mem_we_i,
    input  logic [31:0]                       mem_addr_i,
    input  logic [32*dma_data_width_p-1:0]    mem_wdata_i,
    output logic                              mem_valid_o,
    output logic [32*dma_data_width_p-1:0]    mem_data_o
);

    localparam int unsigned AddrW = $clog2(els_p);
    localparam int unsigned BeatW = (dma_data_width_p > 1) ? $clog2(dma_data_width_p) : 1;
    localparam int unsigned LatW  = (latency_p > 1) ? $clog2(latency_p) : 1;
    localparam int unsigned BlkW  = 32 * dma_data_width_p;

    localparam logic [BeatW-1:0] LastBeat = BeatW'(dma_data_width_p - 1);
    localparam logic [LatW-1:0]  LastWait = LatW'(latency_p - 1);
    // Clears the in-block word offset so every request starts on a block boundary.
    localparam logic [AddrW-1:0] BlkMask  = ~AddrW'(dma_data_width_p - 1);

    typedef enum logic [1:0] {StIdle, StWait, StXfer, StDone} state_e;

    state_e            state_q, state_d;
    logic              we_q;
    logic [AddrW-1:0]  base_q;
    logic [BlkW-1:0]   wdata_q;
    logic [BlkW-1:0]   rdata_q;
    logic [LatW-1:0]   wait_q;
    logic [BeatW-1:0]  beat_q;
    logic [AddrW-1:0]  word_idx;
    logic              accept;

    logic [31:0] mem_q [els_p];

    // Byte-offset bits and bits above the array are deliberately ignored.
    logic unused_addr;
    assign unused_addr = ^{mem_addr_i[31:2+AddrW], mem_addr_i[1:0]};

    // Ready is forced low while reset is held, independent of the state register.
    assign mem_ready_o = (state_q == StIdle) && nreset_i;
    assign accept      = mem_valid_i && mem_ready_o;
    // Base is block-aligned, so OR-ing in the beat index never carries.
    assign word_idx    = base_q | AddrW'(beat_q);
    assign mem_valid_o = (state_q == StDone);
    assign mem_data_o  = rdata_q;

    // State register.
    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: idle -> (latency wait) -> one beat per word -> done pulse.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = (latency_p > 0) ? StWait : StXfer;
                end
            end
            StWait: begin
                if (wait_q == LastWait) begin
                    state_d = StXfer;
                end
            end
            StXfer: begin
                if (beat_q == LastBeat) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Request capture, latency/beat counters and the registered read block.
    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            we_q    <= 1'b0;
            base_q  <= '0;
            wdata_q <= '0;
            wait_q  <= '0;
            beat_q  <= '0;
            rdata_q <= '0;
        end else begin
            if (accept) begin
                we_q    <= mem_we_i;
                base_q  <= mem_addr_i[2 +: AddrW] & BlkMask;
                wdata_q <= mem_wdata_i;
                wait_q  <= '0;
                beat_q  <= '0;
            end
            if (state_q == StWait) begin
                wait_q <= wait_q + 1'b1;
            end
            if (state_q == StXfer) begin
                beat_q <= beat_q + 1'b1;
                if (!we_q) begin
                    rdata_q[32*beat_q +: 32] <= mem_q[word_idx];
                end
            end
        end
    end

    // Word array write port; contents survive reset, and an aborted write keeps
    // the beats that already landed because reset drops the state out of XFER.
    always_ff @(posedge clk_i) begin
        if (state_q == StXfer && we_q) begin
            mem_q[word_idx] <= wdata_q[32*beat_q +: 32];
        end
    end

endmodule

// File: tb/tb_dma_mem_ctrl.sv
// Self-checking bench for dma_mem_ctrl: a transaction-level model predicts
// ready/valid/data every cycle; directed scenarios pin literal results.
module tb_dma_mem_ctrl;

    localparam int unsigned Els = 2048;
    localparam int unsigned D   = 8;
    localparam int unsigned L   = 4;
    localparam int unsigned DW  = 32 * D;

    logic          clk_i       = 1'b0;
    logic          nreset_i    = 1'b1;
    logic          mem_valid_i = 1'b0;
    logic          mem_we_i    = 1'b0;
    logic [31:0]   mem_addr_i  = '0;
    logic [DW-1:0] mem_wdata_i = '0;
    logic          mem_ready_o;
    logic          mem_valid_o;
    logic [DW-1:0] mem_data_o;

    logic          v0    = 1'b0;
    logic          we0   = 1'b0;
    logic [31:0]   addr0 = '0;
    logic [DW-1:0] wd0   = '0;
    logic          rdy0;
    logic          vld0;
    logic [DW-1:0] dat0;

    always #5 clk_i = ~clk_i;

    dma_mem_ctrl #(
        .els_p            (Els),
        .dma_data_width_p (D),
        .latency_p        (L)
    ) u_dut (
        .clk_i       (clk_i),
        .nreset_i    (nreset_i),
        .mem_valid_i (mem_valid_i),
        .mem_ready_o (mem_ready_o),
        .mem_we_i    (mem_we_i),
        .mem_addr_i  (mem_addr_i),
        .mem_wdata_i (mem_wdata_i),
        .mem_valid_o (mem_valid_o),
        .mem_data_o  (mem_data_o)
    );

    dma_mem_ctrl #(
        .els_p            (Els),
        .dma_data_width_p (D),
        .latency_p        (0)
    ) u_dut0 (
        .clk_i       (clk_i),
        .nreset_i    (nreset_i),
        .mem_valid_i (v0),
        .mem_ready_o (rdy0),
        .mem_we_i    (we0),
        .mem_addr_i  (addr0),
        .mem_wdata_i (wd0),
        .mem_valid_o (vld0),
        .mem_data_o  (dat0)
    );

    int errors = 0;
    int checks = 0;

    task automatic check_bit(input string name, input logic got, input logic want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %b want %b at %0t", name, got, want, $time);
        end
    endtask

    task automatic check_int(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d want %0d at %0t", name, got, want, $time);
        end
    endtask

    task automatic check_blk(input string name, input logic [DW-1:0] got,
                             input logic [DW-1:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h at %0t", name, got, want, $time);
        end
    endtask

    function automatic logic [DW-1:0] seq_block(input logic [31:0] first);
        logic [DW-1:0] r;
        for (int k = 0; k < int'(D); k++) r[32*k +: 32] = first + 32'(k);
        return r;
    endfunction

    function automatic int block_base(input logic [31:0] addr);
        int w;
        w = int'((addr >> 2) % Els);
        return (w / int'(D)) * int'(D);
    endfunction

    // ---------------- transaction-level reference model ----------------
    logic [31:0]   model_mem [Els];
    logic [DW-1:0] exp_data = '0;
    logic [DW-1:0] op_wd    = '0;
    bit            busy     = 1'b0;
    bit            op_we    = 1'b0;
    int            acc      = 0;
    int            cyc      = 0;
    int            accepts  = 0;
    int            base     = 0;
    int            n_done   = 0;
    bit            chk_en   = 1'b0;
    int            pulses[$];

    // cyc counts active edges; a request accepted at edge acc completes (valid
    // visible) in the cycle after edge acc+L+D and the bus is idle from acc+L+D+1.
    always @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            if (busy && op_we) begin
                n_done = cyc - acc - int'(L);
                if (n_done < 0) n_done = 0;
                if (n_done > int'(D)) n_done = int'(D);
                for (int k = 0; k < n_done; k++) model_mem[base + k] = op_wd[32*k +: 32];
            end
            busy     = 1'b0;
            exp_data = '0;
        end else begin
            cyc++;
            if (busy) begin
                if (cyc == acc + int'(L + D) + 1) begin
                    busy = 1'b0;
                    if (op_we) begin
                        for (int k = 0; k < int'(D); k++) model_mem[base + k] = op_wd[32*k +: 32];
                    end
                end
            end else if (mem_valid_i) begin
                busy  = 1'b1;
                acc   = cyc;
                accepts++;
                op_we = mem_we_i;
                base  = block_base(mem_addr_i);
                op_wd = mem_wdata_i;
                if (!op_we) begin
                    for (int k = 0; k < int'(D); k++) exp_data[32*k +: 32] = model_mem[base + k];
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk_i) begin
        if (chk_en) begin
            check_bit("ready", mem_ready_o, nreset_i && !busy);
            check_bit("valid", mem_valid_o, busy && (cyc == acc + int'(L + D)));
            if (!(busy && !op_we && cyc < acc + int'(L + D))) begin
                check_blk("data", mem_data_o, exp_data);
            end
            if (mem_valid_o === 1'b1) pulses.push_back(cyc);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic accept_op(input logic we, input logic [31:0] addr, input logic [DW-1:0] wd);
        int start;
        int guard;
        @(negedge clk_i);
        start       = accepts;
        mem_we_i    = we;
        mem_addr_i  = addr;
        mem_wdata_i = wd;
        mem_valid_i = 1'b1;
        guard       = 0;
        while (accepts == start && guard < 64) begin
            @(negedge clk_i);
            guard++;
        end
        mem_valid_i = 1'b0;
        check_bit("accept_in_time", guard < 64, 1'b1);
    endtask

    // Edges from the accept edge to the first edge that samples the pulse.
    task automatic wait_done(output int lat);
        int n;
        n = 0;
        while (mem_valid_o !== 1'b1 && n < 64) begin
            @(negedge clk_i);
            n++;
        end
        lat = n + 1;
    endtask

    task automatic op0(input logic we, input logic [31:0] addr, input logic [DW-1:0] wd,
                       output int lat);
        int n;
        @(negedge clk_i);
        check_bit("l0_ready", rdy0, 1'b1);
        we0   = we;
        addr0 = addr;
        wd0   = wd;
        v0    = 1'b1;
        @(negedge clk_i);
        v0 = 1'b0;
        n  = 0;
        while (vld0 !== 1'b1 && n < 64) begin
            @(negedge clk_i);
            n++;
        end
        lat = n + 1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int            lat;
        int            guard;
        int            start;
        logic [DW-1:0] wd;
        logic [DW-1:0] want;

        #2 nreset_i = 1'b0;
        #1 chk_en = 1'b1;
        repeat (3) @(negedge clk_i);
        check_blk("reset_data", mem_data_o, '0);
        check_bit("reset_ready", mem_ready_o, 1'b0);
        #1 nreset_i = 1'b1;

        // Zero-latency build: write then read, 1+D edges each.
        op0(1'b1, 32'h0000_0040, seq_block(32'h5500), lat);
        check_int("l0_write_lat", lat, 9);
        op0(1'b0, 32'h0000_005C, '0, lat);
        check_int("l0_read_lat", lat, 9);
        check_blk("l0_read_data", dat0, seq_block(32'h5500));

        // Preload word n = n through the write port.
        for (int b = 0; b < int'(Els / D); b++) begin
            accept_op(1'b1, 32'(b * int'(D) * 4), seq_block(32'(b * int'(D))));
            wait_done(lat);
        end

        // Scenario: plain read at 0x40.
        accept_op(1'b0, 32'h0000_0040, '0);
        wait_done(lat);
        check_int("read_lat", lat, 13);
        check_blk("read_0x40", mem_data_o, seq_block(32'h10));

        // Scenario: write block to 0x100, read back from unaligned 0x11C.
        accept_op(1'b1, 32'h0000_0100, seq_block(32'hA0));
        wait_done(lat);
        check_int("write_ack_lat", lat, 13);
        check_blk("write_keeps_data", mem_data_o, seq_block(32'h10));
        accept_op(1'b0, 32'h0000_011C, '0);
        wait_done(lat);
        check_int("read2_lat", lat, 13);
        check_blk("read_0x11c", mem_data_o, seq_block(32'hA0));

        // Scenario: valid held for three back-to-back reads.
        @(negedge clk_i);
        pulses.delete();
        start       = accepts;
        mem_we_i    = 1'b0;
        mem_addr_i  = 32'h0000_0040;
        mem_valid_i = 1'b1;
        guard       = 0;
        while (accepts < start + 3 && guard < 200) begin
            @(negedge clk_i);
            guard++;
        end
        mem_valid_i = 1'b0;
        repeat (30) @(negedge clk_i);
        check_int("b2b_pulses", pulses.size(), 3);
        if (pulses.size() >= 3) begin
            check_int("b2b_gap1", pulses[1] - pulses[0], 14);
            check_int("b2b_gap2", pulses[2] - pulses[1], 14);
        end

        // Scenario: high address bits wrap modulo the array.
        accept_op(1'b0, 32'h0000_2040, '0);
        wait_done(lat);
        check_blk("read_wrap", mem_data_o, seq_block(32'h10));

        // Scenario: reset during write beat 3 (block at word 0x80).
        wd = seq_block(32'hDEAD_0000);
        accept_op(1'b1, 32'h0000_0200, wd);
        pulses.delete();
        repeat (7) @(posedge clk_i);
        #1 nreset_i = 1'b0;
        repeat (2) @(negedge clk_i);
        #1 nreset_i = 1'b1;
        repeat (15) @(negedge clk_i);
        check_int("rst_no_pulse", pulses.size(), 0);
        check_bit("ready_after_rst", mem_ready_o, 1'b1);
        accept_op(1'b0, 32'h0000_0200, '0);
        wait_done(lat);
        for (int k = 0; k < int'(D); k++) begin
            want[32*k +: 32] = (k < 3) ? 32'hDEAD_0000 + 32'(k) : 32'h80 + 32'(k);
        end
        check_blk("rst_partial_write", mem_data_o, want);

        // Randomized traffic; data and handshakes are checked every cycle.
        for (int i = 0; i < 60; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk_i);
            for (int k = 0; k < int'(D); k++) wd[32*k +: 32] = $urandom;
            accept_op(1'($urandom_range(0, 1)), $urandom, wd);
            if ($urandom_range(0, 1) == 1) begin
                wait_done(lat);
                check_int("rand_lat", lat, 13);
            end
        end
        repeat (20) @(negedge clk_i);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
